// File: rtl/mux_serializer_seq.sv
// mux_serializer_seq: turns parallel words into a gap-free select/strobe sequence for an 8:1 bit mux
module mux_serializer_seq #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             hold,
    output logic [WIDTH-1:0] word_out,
    output logic [SEL_W-1:0] sel,
    output logic             bit_valid,
    output logic             sof,
    output logic             eof
);
    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [SEL_W-1:0] ONE   = SEL_W'(1);
    localparam logic [SEL_W-1:0] START = MSB_FIRST ? SEL_W'(WIDTH - 1) : '0;
    localparam logic [SEL_W-1:0] LAST  = MSB_FIRST ? '0 : SEL_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d, pend_q, pend_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             bv_q, bv_d, sof_q, sof_d, eof_q, eof_d, pend_v_q, pend_v_d;
    logic             xfer;

    assign in_ready  = !pend_v_q;
    assign xfer      = in_valid && in_ready;
    assign word_out  = word_q;
    assign sel       = sel_q;
    assign bit_valid = bv_q;
    assign sof       = sof_q;
    assign eof       = eof_q;

    // next-state: load, step, frame-boundary handoff and pending-buffer capture
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        sel_d    = sel_q;
        bv_d     = bv_q;
        sof_d    = sof_q;
        if (state_q == IDLE) begin
            bv_d = 1'b0;
            if (xfer) begin
                word_d  = in_data;
                sel_d   = START;
                bv_d    = 1'b1;
                sof_d   = 1'b1;
                state_d = SHIFT;
            end
        end else begin
            if (xfer) begin
                pend_d   = in_data;
                pend_v_d = 1'b1;
            end
            if (!hold) begin
                if (sel_q != LAST) begin
                    sel_d = MSB_FIRST ? sel_q - ONE : sel_q + ONE;
                    sof_d = 1'b0;
                end else if (pend_v_q) begin
                    word_d   = pend_q;
                    pend_v_d = 1'b0;
                    sel_d    = START;
                    sof_d    = 1'b1;
                end else if (xfer) begin
                    word_d   = in_data;
                    pend_v_d = 1'b0;
                    sel_d    = START;
                    sof_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                    bv_d    = 1'b0;
                    sof_d   = 1'b0;
                    sel_d   = START;
                end
            end
        end
        eof_d = bv_d && (sel_d == LAST);
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            word_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            sel_q    <= START;
            bv_q     <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            sel_q    <= sel_d;
            bv_q     <= bv_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
        end
    end
endmodule
